// File: rtl/dm_load_ctrl_pkg.sv
// Shared data-memory op encodings and load-controller FSM states.
// The store-side byte-enable logic and the load controller both import this.
package dm_load_ctrl_pkg;

    localparam logic [3:0] DM_SW  = 4'b0001;
    localparam logic [3:0] DM_SH  = 4'b0010;
    localparam logic [3:0] DM_SB  = 4'b0011;
    localparam logic [3:0] DM_LW  = 4'b0100;
    localparam logic [3:0] DM_LH  = 4'b0101;
    localparam logic [3:0] DM_LHU = 4'b0110;
    localparam logic [3:0] DM_LB  = 4'b0111;
    localparam logic [3:0] DM_LBU = 4'b1000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == DM_LW) || (op == DM_LH) || (op == DM_LHU) ||
               (op == DM_LB) || (op == DM_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == DM_SW) || (op == DM_SH) || (op == DM_SB);
    endfunction

    // Bytes are never misaligned; halves need addr[0]=0, words need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        return ((op == DM_LW) && (lo != 2'b00)) ||
               (((op == DM_LH) || (op == DM_LHU)) && lo[0]);
    endfunction

endpackage

// File: rtl/dm_load_ctrl_load_ext.sv
// Selects the addressed byte/half of a bus word and sign- or zero-extends it.
module load_ext
    import dm_load_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  dmop,
    output logic [31:0] result
);

    logic [15:0] half;
    logic [7:0]  byte_v;

    assign half = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        byte_v = word[7:0];
        case (addr_lo)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
    end

    always_comb begin
        result = word;
        case (dmop)
            DM_LH:   result = {{16{half[15]}}, half};
            DM_LHU:  result = {16'h0000, half};
            DM_LB:   result = {{24{byte_v[7]}}, byte_v};
            DM_LBU:  result = {24'h000000, byte_v};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dm_load_ctrl.sv
// Data-memory load controller: issues one bus read per load, stalls the
// pipeline until ack or timeout, and returns the extracted/extended result.
module dm_load_ctrl
    import dm_load_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [3:0]  DMOp,
    input  logic        req,
    output logic        m_rd_req,
    output logic [31:0] m_rd_addr,
    input  logic        m_rd_ack,
    input  logic [31:0] m_rd_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc_adel
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  cnt;
    logic [1:0]  lat_lo;
    logic [3:0]  lat_op;
    logic [31:0] ext_res;
    logic        accept, misalign, ack_hit, to_hit;

    load_ext u_ext (
        .word    (m_rd_data),
        .addr_lo (lat_lo),
        .dmop    (lat_op),
        .result  (ext_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        misalign = 1'b0;
        ack_hit  = 1'b0;
        to_hit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !req && is_load(DMOp)) begin
                    if (is_misaligned(DMOp, addr[1:0])) begin
                        misalign = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (m_rd_ack) begin
                    ack_hit = 1'b1;
                    state_n = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    to_hit  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 8'd0;
            lat_lo    <= 2'd0;
            lat_op    <= 4'd0;
            m_rd_addr <= 32'd0;
            rdata     <= 32'd0;
            done      <= 1'b0;
            exc_adel  <= 1'b0;
        end else begin
            done     <= ack_hit;
            exc_adel <= misalign | to_hit;
            cnt      <= (state == ST_WAIT && state_n == ST_WAIT) ? cnt + 8'd1 : 8'd0;
            if (accept) begin
                lat_lo    <= addr[1:0];
                lat_op    <= DMOp;
                m_rd_addr <= {addr[31:2], 2'b00};
            end
            if (ack_hit) rdata <= ext_res;
        end
    end

    assign busy     = (state == ST_WAIT);
    assign m_rd_req = (state == ST_WAIT);

endmodule

// File: tb/tb_dm_load_ctrl.sv
// Directed bench for dm_load_ctrl with a result scoreboard checked on done.
module tb_dm_load_ctrl;
    import dm_load_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [3:0]  DMOp = 4'd0;
    logic        req = 1'b0;
    logic        m_rd_req;
    logic [31:0] m_rd_addr;
    logic        m_rd_ack = 1'b0;
    logic [31:0] m_rd_data = 32'd0;
    logic        busy, done, exc_adel;
    logic [31:0] rdata;

    int n_chk = 0;
    int n_fail = 0;
    int n_exc = 0;
    int n_done = 0;
    logic [31:0] sb_q[$];
    logic [31:0] model_rdata = 32'd0;

    dm_load_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .DMOp(DMOp),
        .req(req), .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr),
        .m_rd_ack(m_rd_ack), .m_rd_data(m_rd_data), .busy(busy),
        .done(done), .rdata(rdata), .exc_adel(exc_adel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_ext(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (8 * a[1:0]);
        if (op == DM_LH)  return (sh[15]) ? (sh | 32'hFFFF0000) : (sh & 32'h0000FFFF);
        if (op == DM_LHU) return sh & 32'h0000FFFF;
        if (op == DM_LB)  return (sh[7]) ? (sh | 32'hFFFFFF00) : (sh & 32'h000000FF);
        if (op == DM_LBU) return sh & 32'h000000FF;
        return w;
    endfunction

    always @(negedge clk) begin
        if (exc_adel) n_exc++;
        if (done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                model_rdata = sb_q.pop_front();
                chk("sb_rdata", rdata, model_rdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a);
        start = 1'b1; DMOp = op; addr = a;
        step();
        start = 1'b0;
    endtask

    // Issues a load and acks it in WAIT cycle ack_cyc (0 = first WAIT cycle).
    task automatic load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w,
                        input int ack_cyc, input string tag);
        sb_q.push_back(model_ext(op, a, w));
        issue(op, a);
        for (int i = 0; i < ack_cyc; i++) step();
        chk({tag, "_addr"}, m_rd_addr, {a[31:2], 2'b00});
        m_rd_ack = 1'b1; m_rd_data = w;
        step();
        m_rd_ack = 1'b0;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        step();
    endtask

    initial begin
        int e0, d0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {31'd0, m_rd_req}, 32'd0);
        chk("rst_addr", m_rd_addr, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done_exc", {30'd0, done, exc_adel}, 32'd0);
        step(); step();
        reset = 1'b0;
        step();

        // lb 0x1003, ack first WAIT cycle: done two edges after start
        sb_q.push_back(model_ext(DM_LB, 32'h1003, 32'h80AABBCC));
        issue(DM_LB, 32'h1003);
        chk("lb_busy", {31'd0, busy}, 32'd1);
        chk("lb_req", {31'd0, m_rd_req}, 32'd1);
        chk("lb_maddr", m_rd_addr, 32'h1000);
        m_rd_ack = 1'b1; m_rd_data = 32'h80AABBCC;
        step();
        m_rd_ack = 1'b0;
        chk("lb_done", {31'd0, done}, 32'd1);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        step();
        chk("lb_done_pulse", {31'd0, done}, 32'd0);

        // lhu 0x2002, busy for exactly 5 cycles
        sb_q.push_back(model_ext(DM_LHU, 32'h2002, 32'h8001FFFF));
        issue(DM_LHU, 32'h2002);
        for (int i = 0; i < 5; i++) begin
            chk("lhu_busy", {31'd0, busy}, 32'd1);
            chk("lhu_hold_addr", m_rd_addr, 32'h2000);
            if (i == 4) begin m_rd_ack = 1'b1; m_rd_data = 32'h8001FFFF; end
            step();
        end
        m_rd_ack = 1'b0;
        chk("lhu_busy_low", {31'd0, busy}, 32'd0);
        chk("lhu_rdata", rdata, 32'h00008001);
        step();

        // misaligned lw
        e0 = n_exc;
        issue(DM_LW, 32'h3001);
        chk("mis_exc", {31'd0, exc_adel}, 32'd1);
        chk("mis_req", {31'd0, m_rd_req}, 32'd0);
        chk("mis_busy", {31'd0, busy}, 32'd0);
        step();
        chk("mis_exc_pulse", {31'd0, exc_adel}, 32'd0);
        chk("mis_exc_count", n_exc - e0, 1);
        // misaligned lh
        issue(DM_LH, 32'h3003);
        chk("mis_lh_exc", {31'd0, exc_adel}, 32'd1);
        step();

        // timeout: no ack for 16 WAIT cycles
        e0 = n_exc; d0 = n_done;
        issue(DM_LW, 32'h5000);
        for (int i = 0; i < 16; i++) begin
            chk("to_busy", {31'd0, busy}, 32'd1);
            step();
        end
        chk("to_exc", {31'd0, exc_adel}, 32'd1);
        chk("to_busy_low", {31'd0, busy}, 32'd0);
        chk("to_rdata_kept", rdata, model_rdata);
        step();
        chk("to_exc_count", n_exc - e0, 1);
        chk("to_no_done", n_done - d0, 0);

        // ack coincident with timeout: ack wins
        e0 = n_exc;
        load(DM_LW, 32'h5004, 32'hDEADBEEF, 15, "to_ack");
        chk("to_ack_no_exc", n_exc - e0, 0);

        // lb/lbu positive byte and zero-extension, lh sign extension
        load(DM_LB, 32'h4001, 32'h12347F56, 0, "lb_pos");
        chk("lb_pos_val", rdata, 32'h0000007F);
        load(DM_LBU, 32'h4001, 32'h1234FF56, 2, "lbu");
        chk("lbu_val", rdata, 32'h000000FF);
        load(DM_LH, 32'h7002, 32'h87651234, 1, "lh_hi");
        load(DM_LH, 32'h7000, 32'h00008001, 0, "lh_lo");
        load(DM_LW, 32'h7008, 32'hCAFEF00D, 3, "lw");

        // ignored starts: req=1, store code, start during WAIT, ack in IDLE
        e0 = n_exc; d0 = n_done;
        req = 1'b1;
        issue(DM_LW, 32'h8000);
        req = 1'b0;
        chk("irq_busy", {31'd0, busy}, 32'd0);
        issue(DM_SW, 32'h8000);
        chk("store_busy", {31'd0, busy}, 32'd0);
        m_rd_ack = 1'b1; m_rd_data = 32'h11111111;
        step();
        m_rd_ack = 1'b0;
        chk("idle_ack_busy", {31'd0, busy}, 32'd0);
        step();
        chk("ignored_no_pulse", (n_exc - e0) + (n_done - d0), 0);
        chk("ignored_rdata", rdata, model_rdata);

        sb_q.push_back(model_ext(DM_LBU, 32'h9003, 32'hAB000000));
        issue(DM_LBU, 32'h9003);
        issue(DM_LW, 32'hA000);
        chk("wait_start_addr", m_rd_addr, 32'h9000);
        m_rd_ack = 1'b1; m_rd_data = 32'hAB000000;
        step();
        m_rd_ack = 1'b0;
        chk("wait_start_rdata", rdata, 32'h000000AB);
        step();
        chk("wait_start_idle", {31'd0, busy}, 32'd0);

        // reset mid-WAIT abandons the read
        e0 = n_exc; d0 = n_done;
        issue(DM_LW, 32'h6000);
        step();
        reset = 1'b1;
        #1;
        sb_q.delete();
        model_rdata = 32'd0;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_req", {31'd0, m_rd_req}, 32'd0);
        chk("mrst_addr", m_rd_addr, 32'd0);
        chk("mrst_rdata", rdata, 32'd0);
        step();
        reset = 1'b0;
        m_rd_ack = 1'b1; m_rd_data = 32'h55555555;
        step();
        m_rd_ack = 1'b0;
        step();
        chk("mrst_late_ack_busy", {31'd0, busy}, 32'd0);
        chk("mrst_late_ack_rdata", rdata, 32'd0);
        chk("mrst_no_pulse", (n_exc - e0) + (n_done - d0), 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dm_load_ctrl.md
DM_LOAD_CTRL -- requirements
Module: dm_load_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles in WAIT before abort, legal range 2..255.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port start, input, 1: load issued this cycle.
REQ-005 Port addr, input, 32: byte address of the load.
REQ-006 Port DMOp, input, 4: 0100 lw, 0101 lh, 0110 lhu, 0111 lb, 1000 lbu; other codes are not loads.
REQ-007 Port req, input, 1: interrupt request; when high, the load is cancelled at issue.
REQ-008 Port m_rd_req, output, 1: bus read request.
REQ-009 Port m_rd_addr, output, 32: word-aligned bus address, {addr[31:2],2'b00}.
REQ-010 Port m_rd_ack, input, 1: bus read response valid.
REQ-011 Port m_rd_data, input, 32: bus read word, valid with m_rd_ack.
REQ-012 Port busy, output, 1: stall for the pipeline, high while a read is outstanding.
REQ-013 Port done, output, 1: one-cycle pulse when rdata is updated.
REQ-014 Port rdata, output, 32: extracted and extended load result.
REQ-015 Port exc_adel, output, 1: one-cycle pulse for a misaligned load or a bus timeout.

Function
REQ-016 FSM states: IDLE and WAIT.
REQ-017 IDLE accepts a load when start=1, req=0, and DMOp is a load code.
  - aligned load -> latch addr[1:0] and DMOp, go to WAIT.
  - misaligned load (lw with addr[1:0]!=0; lh/lhu with addr[0]=1) -> exc_adel=1 next cycle, no bus request, stay IDLE.
REQ-018 start with req=1 or a non-load DMOp is ignored: no state change, no pulse.
REQ-019 In WAIT: m_rd_req=1, m_rd_addr = latched word address; both are held stable until ack.
REQ-020 In WAIT, m_rd_ack=1 -> the next edge updates rdata, pulses done for one cycle, and returns to IDLE.
  - minimum start-to-done latency is 2 cycles (ack in the first WAIT cycle).
REQ-021 Extraction by latched addr[1:0]:
  - lw: the whole word.
  - lh/lhu: half at bits [15:0] when addr[1]=0, [31:16] when addr[1]=1.
  - lb/lbu: byte at 8*addr[1:0].
  - lh/lb sign-extend to 32 bits; lhu/lbu zero-extend.
REQ-022 WAIT cycle counter starts at 0 on entry and increments each cycle without ack.
  - counter reaching TIMEOUT-1 with no ack -> IDLE, exc_adel pulse, rdata unchanged, no done.
REQ-023 Ack and timeout in the same cycle -> ack wins (done, no exc_adel).
REQ-024 busy=1 exactly while state=WAIT; start during WAIT is ignored.
REQ-025 m_rd_ack while IDLE is ignored.
REQ-026 m_rd_req=0 in IDLE.
REQ-027 rdata holds its last value between loads.

Reset
REQ-028 reset asserted -> immediately: state=IDLE, counter=0, m_rd_req=0, m_rd_addr=0, busy=0, done=0, exc_adel=0, rdata=0.
REQ-029 reset mid-WAIT abandons the read: no done, no exc_adel; a late ack after reset release is ignored per REQ-025.

Structure
REQ-030 The DMOp load/store encodings (including store codes sw 0001, sh 0010, sb 0011) and FSM state constants SHALL live in a shared package used by the store-side byte-enable logic and this block.
REQ-031 Byte/half extraction and extension SHALL be one combinational sub-module, load_ext (inputs: word, addr[1:0], DMOp; output: 32-bit result).

Verification
REQ-032 lb, addr=0x1003, ack in the first WAIT cycle with data 0x80AABBCC -> done after 2 cycles, rdata=0xFFFFFF80, m_rd_addr=0x1000.
REQ-033 lhu, addr=0x2002, data 0x8001FFFF, ack after 5 WAIT cycles -> busy high for 5 cycles then low, rdata=0x00008001.
REQ-034 lw, addr=0x3001 -> exc_adel pulse next cycle, m_rd_req never asserted, busy stays 0.
REQ-035 lw, no ack, TIMEOUT=16 -> exc_adel pulse after 16 WAIT cycles, no done, rdata unchanged; ack on cycle 16 -> done only.
REQ-036 start with req=1 -> no transaction; separately, reset asserted mid-WAIT then an ack after release -> no done, all outputs 0.
REQ-037 lb, addr=0x4001, data 0x12347F56 -> rdata=0x0000007F; lbu, same address and data 0x1234FF56 -> rdata=0x000000FF.
